mm_job_arbiter: RTL and testbench
=================================

# mm_job_arbiter

Shares one `matrix_multiplier` instance between two requesters. The block arbitrates round-robin and buffers the granted requester's 18 operand bytes (A then B, 3x3 row-major). It replays them to the multiplier as an uninterrupted 18-cycle burst, captures the 9 serial 16-bit results, and returns them to the owner with valid/ready backpressure. It sits between the requester stream logic and the `matrix_multiplier` `start/in/o/done` port.

## Interface
- `DATA_W`, 8, operand width; must equal multiplier `in` width
- `RES_W`, 16, result width; must equal multiplier `o` width
- `DONE_TIMEOUT`, 64, max cycles in WAIT before abort (>= 1)
- `clk` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-high; clears all state
- `req_valid` in 2: per-requester operand byte valid
- `req_data0`, `req_data1` in DATA_W: operand byte of requester 0 / 1
- `req_ready` out 2: operand accept, one-hot or zero
- `res_valid` out 1: result word valid
- `res_data` out RES_W: result c[k]
- `res_id` out 1: owning requester of current result
- `res_last` out 1: high with c[8]
- `res_ready` in 1: result accept
- `mm_start` out 1: to multiplier `start`
- `mm_in` out DATA_W: to multiplier `in`
- `mm_o` in RES_W: from multiplier `o`
- `mm_done` in 1: from multiplier `done`
- `busy` out 1: high in any state except IDLE
- `err_timeout` out 1: one-cycle pulse on WAIT abort

## Operation
- States: IDLE, LOAD, ISSUE, WAIT, CAPTURE, DRAIN.
- **IDLE**
  - If any `req_valid`, register grant `g` and go to LOAD.
  - If both are valid, grant the requester not granted last. After reset, requester 0 wins the first tie.
- **LOAD**
  - `req_ready[g]`=1 while `ld_cnt`<18.
  - A byte is accepted on `req_valid[g]&req_ready[g]` and written to `op_buf[ld_cnt]`.
  - Gaps in `req_valid` stall the load without limit.
  - After the 18th accept, go to ISSUE.
  - The non-granted requester sees `req_ready`=0 until it is granted.
- **ISSUE**
  - 18 consecutive cycles: `mm_start`=1, `mm_in`=`op_buf[k]`, k=0..17.
  - Then go to WAIT with `mm_start`=0 and `mm_in`=0.
- **WAIT**
  - Count cycles.
  - If `mm_done`=1, go to CAPTURE. The `mm_o` value in the first `mm_done` cycle is c[0] and is stored in that same cycle.
  - If the count reaches `DONE_TIMEOUT` without `mm_done`, pulse `err_timeout`, go to IDLE, and return no results. The grant still counts as used for round-robin.
- **CAPTURE**
  - Store `mm_o` on each of the next 8 cycles into `res_buf[1..8]`, independent of `mm_done` level.
  - Then go to DRAIN.
- **DRAIN**
  - `res_valid`=1, `res_data`=`res_buf[k]`, `res_id`=g, `res_last`=(k==8).
  - k advances on `res_valid&res_ready`.
  - After the c[8] accept, go to IDLE and record g as last granted.
- Results are captured verbatim. The block does no arithmetic; width checks are by parameter only.

## Timing
- **Reset values:** `req_ready`=0, `res_valid`=0, `res_data`=0, `res_id`=0, `res_last`=0, `mm_start`=0, `mm_in`=0, `busy`=0, `err_timeout`=0. State is IDLE and last-grant is 1.
- **Reset mid-operation:** abort immediately. Any in-flight multiplier job is abandoned. Buffers need not be cleared, but all counters are cleared.
- All outputs are registered and come from the state or buffer registers.
- **Grant latency:** `req_valid` high at IDLE edge N gives `req_ready[g]` high from cycle N+1.
- **Best case, no stalls:**
  - 18 LOAD cycles.
  - ISSUE starts the cycle after the 18th accept.
  - First `mm_start` is 19 cycles after the grant edge.
- `mm_done` seen during ISSUE is ignored.
- **DRAIN throughput:** with `res_ready` held at 1, 9 words are delivered on 9 consecutive cycles.
- A request arriving on the other port during a job waits; it is granted in the IDLE cycle after DRAIN.
- **Back-to-back:** with both ports continuously valid, grants alternate 0,1,0,1…

## Test plan
- **Basic job:** requester 0 sends A=1..9, B=9..1 with no gaps; real multiplier attached, `res_ready`=1.
  - Results are 30,24,18,84,69,54,138,114,90 with `res_id`=0.
  - `res_last` is high only on 90; `busy` falls after the last word.
- **Tie:** both `req_valid` asserted in the same cycle after reset.
  - Requester 0 served first, then requester 1.
  - Requester 1 (same data) gets identical results with `res_id`=1.
- **Load stall:** requester drops `req_valid` for 5 cycles after byte 7.
  - No `mm_start` during the stall; ISSUE still shows 18 contiguous `mm_in` bytes 1..9,9..1.
- **Backpressure:** `res_ready` toggles 1,0,1,0….
  - Each word is held stable until accepted; all 9 results arrive in order.
- **Timeout:** `DONE_TIMEOUT`=20, stub multiplier never asserts `mm_done`.
  - `err_timeout` pulses once 20 cycles after ISSUE ends; `res_valid` never asserts; IDLE returns and the next requester is granted.
- **Reset mid-ISSUE:** assert `reset` at ISSUE byte 10.
  - All outputs are at reset values in the same cycle.
  - After release, a fresh job completes with correct results.

Source files
------------

// File: rtl/mm_job_arbiter.sv
// Round-robin front end sharing one serial 3x3 matrix multiplier between two
// requesters: buffers 18 operand bytes, replays them, returns 9 results.
module mm_job_arbiter #(
   parameter int DATA_W       = 8,
   parameter int RES_W        = 16,
   parameter int DONE_TIMEOUT = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        req_valid,
   input  logic [DATA_W-1:0] req_data0,
   input  logic [DATA_W-1:0] req_data1,
   output logic [1:0]        req_ready,
   output logic              res_valid,
   output logic [RES_W-1:0]  res_data,
   output logic              res_id,
   output logic              res_last,
   input  logic              res_ready,
   output logic              mm_start,
   output logic [DATA_W-1:0] mm_in,
   input  logic [RES_W-1:0]  mm_o,
   input  logic              mm_done,
   output logic              busy,
   output logic              err_timeout
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_LOAD  = 3'd1;
   localparam logic [2:0] S_ISSUE = 3'd2;
   localparam logic [2:0] S_WAIT  = 3'd3;
   localparam logic [2:0] S_CAPT  = 3'd4;
   localparam logic [2:0] S_DRAIN = 3'd5;

   localparam int TW = $clog2(DONE_TIMEOUT + 1);
   localparam logic [TW-1:0] TO_LAST = TW'(DONE_TIMEOUT - 1);

   logic [2:0]        r_state;
   logic              r_g;
   logic              r_last;
   logic [4:0]        r_ld_cnt;
   logic [4:0]        r_cnt;
   logic [TW-1:0]     r_to;
   logic [1:0]        r_req_ready;
   logic              r_res_valid;
   logic [RES_W-1:0]  r_res_data;
   logic              r_res_id;
   logic              r_res_last;
   logic              r_mm_start;
   logic [DATA_W-1:0] r_mm_in;
   logic              r_busy;
   logic              r_err;

   logic [DATA_W-1:0] r_op_buf  [0:17];
   logic [RES_W-1:0]  r_res_buf [0:8];

   logic [DATA_W-1:0] w_data;
   logic              w_ld_acc;
   logic              w_grant;
   logic              w_cap;
   logic              w_acc;

   assign w_data   = r_g ? req_data1 : req_data0;
   assign w_ld_acc = (r_state == S_LOAD) & req_valid[r_g]
                   & r_req_ready[r_g];
   // on a tie the requester not served last wins
   assign w_grant  = (req_valid == 2'b11) ? ~r_last : req_valid[1];
   assign w_cap    = ((r_state == S_WAIT) & mm_done)
                   | (r_state == S_CAPT);
   assign w_acc    = r_res_valid & res_ready;

   assign req_ready   = r_req_ready;
   assign res_valid   = r_res_valid;
   assign res_data    = r_res_data;
   assign res_id      = r_res_id;
   assign res_last    = r_res_last;
   assign mm_start    = r_mm_start;
   assign mm_in       = r_mm_in;
   assign busy        = r_busy;
   assign err_timeout = r_err;

   always_ff @(posedge clk) begin
      if (w_ld_acc)
         r_op_buf[r_ld_cnt] <= w_data;
      if (w_cap)
         r_res_buf[r_cnt[3:0]] <= mm_o;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_g         <= 1'b0;
         r_last      <= 1'b1;
         r_ld_cnt    <= '0;
         r_cnt       <= '0;
         r_to        <= '0;
         r_req_ready <= '0;
         r_res_valid <= 1'b0;
         r_res_data  <= '0;
         r_res_id    <= 1'b0;
         r_res_last  <= 1'b0;
         r_mm_start  <= 1'b0;
         r_mm_in     <= '0;
         r_busy      <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_err <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (|req_valid) begin
                  r_g         <= w_grant;
                  r_req_ready <= w_grant ? 2'b10 : 2'b01;
                  r_ld_cnt    <= '0;
                  r_busy      <= 1'b1;
                  r_state     <= S_LOAD;
               end
            end
            S_LOAD: begin
               if (w_ld_acc) begin
                  if (r_ld_cnt == 5'd17) begin
                     r_req_ready <= '0;
                     r_cnt       <= '0;
                     r_mm_start  <= 1'b1;
                     r_mm_in     <= r_op_buf[0];
                     r_state     <= S_ISSUE;
                  end else begin
                     r_ld_cnt <= r_ld_cnt + 5'd1;
                  end
               end
            end
            S_ISSUE: begin
               if (r_cnt == 5'd17) begin
                  r_mm_start <= 1'b0;
                  r_mm_in    <= '0;
                  r_cnt      <= '0;
                  r_to       <= '0;
                  r_state    <= S_WAIT;
               end else begin
                  r_cnt   <= r_cnt + 5'd1;
                  r_mm_in <= r_op_buf[r_cnt + 5'd1];
               end
            end
            S_WAIT: begin
               if (mm_done) begin
                  r_cnt   <= 5'd1;
                  r_state <= S_CAPT;
               end else if (r_to == TO_LAST) begin
                  r_err   <= 1'b1;
                  r_last  <= r_g;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end else begin
                  r_to <= r_to + 1'b1;
               end
            end
            S_CAPT: begin
               if (r_cnt == 5'd8) begin
                  r_cnt       <= '0;
                  r_res_valid <= 1'b1;
                  r_res_data  <= r_res_buf[0];
                  r_res_id    <= r_g;
                  r_res_last  <= 1'b0;
                  r_state     <= S_DRAIN;
               end else begin
                  r_cnt <= r_cnt + 5'd1;
               end
            end
            S_DRAIN: begin
               if (w_acc) begin
                  if (r_cnt == 5'd8) begin
                     r_res_valid <= 1'b0;
                     r_res_last  <= 1'b0;
                     r_res_data  <= '0;
                     r_last      <= r_g;
                     r_busy      <= 1'b0;
                     r_state     <= S_IDLE;
                  end else begin
                     r_cnt      <= r_cnt + 5'd1;
                     r_res_data <= r_res_buf[r_cnt[3:0] + 4'd1];
                     r_res_last <= (r_cnt == 5'd7);
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mm_job_arbiter.sv
// Bench for mm_job_arbiter: behavioural multiplier stub plus a matrix
// reference model; directed steps with randomized operand data.
module tb_mm_job_arbiter;

   typedef logic [7:0]  job_t [0:17];
   typedef logic [15:0] res_t [0:8];

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  req_valid;
   logic [7:0]  req_data0;
   logic [7:0]  req_data1;
   logic [1:0]  req_ready;
   logic        res_valid;
   logic [15:0] res_data;
   logic        res_id;
   logic        res_last;
   logic        res_ready;
   logic        mm_start;
   logic [7:0]  mm_in;
   logic [15:0] mm_o;
   logic        mm_done;
   logic        busy;
   logic        err_timeout;

   always #5 clk = ~clk;

   mm_job_arbiter #(
      .DATA_W       (8),
      .RES_W        (16),
      .DONE_TIMEOUT (20)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .req_valid   (req_valid),
      .req_data0   (req_data0),
      .req_data1   (req_data1),
      .req_ready   (req_ready),
      .res_valid   (res_valid),
      .res_data    (res_data),
      .res_id      (res_id),
      .res_last    (res_last),
      .res_ready   (res_ready),
      .mm_start    (mm_start),
      .mm_in       (mm_in),
      .mm_o        (mm_o),
      .mm_done     (mm_done),
      .busy        (busy),
      .err_timeout (err_timeout)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // C = A x B, 3x3 row-major, A in bytes 0..8, B in bytes 9..17
   function automatic res_t ref_mm(input job_t b);
      res_t r;
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++) begin
            int s = 0;
            for (int k = 0; k < 3; k++)
               s += int'(b[i*3+k]) * int'(b[9+k*3+j]);
            r[i*3+j] = 16'(s);
         end
      return r;
   endfunction

   function automatic int pick(input logic [1:0] v, input int last);
      if (v == 2'b11) return 1 - last;
      return v[1] ? 1 : 0;
   endfunction

   function automatic job_t rjob();
      job_t j;
      for (int i = 0; i < 18; i++) j[i] = 8'($urandom_range(0, 255));
      return j;
   endfunction

   // multiplier stub: collects a burst, then streams 9 results after a delay
   bit         dead = 1'b0;
   bit         spur = 1'b0;
   logic [7:0] iq[$];
   int         bursts = 0;
   bit         prev_start = 1'b0;
   int         dly = 0;
   int         outk = -1;
   res_t       mc;
   job_t       mtmp;

   always @(negedge clk) begin
      if (reset) begin
         iq.delete();
         prev_start = 1'b0;
         dly = 0;
         outk = -1;
         mm_done = 1'b0;
         mm_o = '0;
      end else begin
         mm_done = 1'b0;
         mm_o = '0;
         if (mm_start) begin
            if (!prev_start) begin
               iq.delete();
               bursts++;
            end
            iq.push_back(mm_in);
            if (spur && iq.size() == 5) begin
               mm_done = 1'b1;
               mm_o = 16'hdead;
            end
            if (iq.size() == 18 && !dead) begin
               for (int i = 0; i < 18; i++) mtmp[i] = iq[i];
               mc = ref_mm(mtmp);
               dly = $urandom_range(1, 6);
            end
         end else if (dly > 0) begin
            dly--;
            if (dly == 0) outk = 0;
         end
         if (outk >= 0) begin
            mm_done = 1'b1;
            mm_o = mc[outk];
            outk = (outk == 8) ? -1 : outk + 1;
         end
         prev_start = mm_start;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int id, input logic v, input logic [7:0] d);
      if (id == 1) begin
         req_valid[1] = v;
         req_data1 = d;
      end else begin
         req_valid[0] = v;
         req_data0 = d;
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_rdy"}, req_ready, 0);
      chk({tag, "_rv"}, res_valid, 0);
      chk({tag, "_rd"}, res_data, 0);
      chk({tag, "_rid"}, res_id, 0);
      chk({tag, "_rl"}, res_last, 0);
      chk({tag, "_st"}, mm_start, 0);
      chk({tag, "_in"}, mm_in, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_err"}, err_timeout, 0);
   endtask

   task automatic grant_chk(input int id);
      tick();
      chk("grant", req_ready, (id == 1) ? 2'b10 : 2'b01);
      chk("busy_on", busy, 1);
   endtask

   task automatic send(input int id, input job_t b, input int st_at,
                       input int st_len);
      int w;
      bit bad = 1'b0;
      for (int i = 0; i < 18; i++) begin
         if (i == st_at) begin
            drive(id, 1'b0, 8'h00);
            for (int s = 0; s < st_len; s++) begin
               tick();
               chk("stall_nostart", mm_start, 0);
            end
         end
         drive(id, 1'b1, b[i]);
         w = 0;
         while (req_ready[id] !== 1'b1 && w < 100) begin
            tick();
            w++;
         end
         if (w >= 100) bad = 1'b1;
         tick();
      end
      drive(id, 1'b0, 8'h00);
      chk("load_bound", bad, 0);
      chk("issue_go", mm_start, 1);
      chk("ready_off", req_ready, 0);
   endtask

   task automatic collect(input int id, input res_t c, input int mode);
      int w = 0;
      int k = 0;
      int cyc = 0;
      logic [15:0] hold;
      logic held;
      logic r;
      res_ready = 1'b0;
      while (res_valid !== 1'b1 && w < 200) begin
         tick();
         w++;
      end
      chk("res_arrive", res_valid, 1);
      while (k < 9 && cyc < 100) begin
         if (mode == 0) r = 1'b1;
         else if (mode == 1) r = ((cyc % 2) == 0);
         else r = 1'($urandom_range(0, 1));
         res_ready = r;
         if (res_valid === 1'b1 && r) begin
            chk("res_data", res_data, c[k]);
            chk("res_id", res_id, id);
            chk("res_last", res_last, (k == 8));
            k++;
         end
         hold = res_data;
         held = (res_valid === 1'b1) && !r;
         tick();
         cyc++;
         if (held) chk("res_hold", res_data, hold);
      end
      res_ready = 1'b0;
      chk("res_count", k, 9);
      if (mode == 0) chk("res_tput", cyc, 9);
      chk("res_end_valid", res_valid, 0);
      chk("busy_fall", busy, 0);
   endtask

   task automatic issue_chk(input job_t b, input int b0);
      chk("issue_bursts", bursts - b0, 1);
      chk("issue_len", iq.size(), 18);
      for (int i = 0; i < 18 && i < iq.size(); i++)
         chk("issue_byte", iq[i], b[i]);
   endtask

   job_t basic;
   res_t bexp;
   job_t j, j2, j3, jd;
   job_t jq [0:1];
   int   exp_last;
   int   g, b0, w, id;
   logic rv;

   initial begin
      for (int i = 0; i < 9; i++) begin
         basic[i] = 8'(i + 1);
         basic[9+i] = 8'(9 - i);
      end
      bexp = '{16'd30, 16'd24, 16'd18, 16'd84, 16'd69, 16'd54,
               16'd138, 16'd114, 16'd90};
      reset = 1'b1;
      req_valid = 2'b00;
      req_data0 = '0;
      req_data1 = '0;
      res_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_reset("rst");
      reset = 1'b0;
      tick();
      chk_reset("idle");
      exp_last = 1;

      // basic job on requester 0
      drive(0, 1'b1, basic[0]);
      chk("ready_pre", req_ready, 0);
      grant_chk(pick(2'b01, exp_last));
      b0 = bursts;
      send(0, basic, -1, 0);
      collect(0, bexp, 0);
      issue_chk(basic, b0);
      exp_last = 0;

      // tie straight after reset
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
      exp_last = 1;
      drive(0, 1'b1, basic[0]);
      drive(1, 1'b1, basic[0]);
      g = pick(2'b11, exp_last);
      grant_chk(g);
      send(g, basic, -1, 0);
      collect(g, bexp, 0);
      exp_last = g;
      g = pick(2'b10, exp_last);
      grant_chk(g);
      send(g, basic, -1, 0);
      collect(g, bexp, 0);
      exp_last = g;

      // load stall, toggling backpressure, spurious done during issue
      spur = 1'b1;
      drive(0, 1'b1, basic[0]);
      grant_chk(0);
      b0 = bursts;
      send(0, basic, 7, 5);
      collect(0, bexp, 1);
      issue_chk(basic, b0);
      spur = 1'b0;
      exp_last = 0;

      // random single-requester jobs
      for (int t = 0; t < 4; t++) begin
         id = int'($urandom_range(0, 1));
         j = rjob();
         spur = 1'($urandom_range(0, 1));
         drive(id, 1'b1, j[0]);
         grant_chk(id);
         b0 = bursts;
         send(id, j, int'($urandom_range(0, 17)),
              int'($urandom_range(0, 3)));
         collect(id, ref_mm(j), 2);
         issue_chk(j, b0);
         exp_last = id;
      end
      spur = 1'b0;

      // both ports continuously valid: grants alternate
      jq[0] = rjob();
      jq[1] = rjob();
      drive(0, 1'b1, jq[0][0]);
      drive(1, 1'b1, jq[1][0]);
      for (int t = 0; t < 4; t++) begin
         g = pick(2'b11, exp_last);
         grant_chk(g);
         b0 = bursts;
         send(g, jq[g], -1, 0);
         jd = jq[g];
         jq[g] = rjob();
         drive(g, 1'b1, jq[g][0]);
         collect(g, ref_mm(jd), 0);
         issue_chk(jd, b0);
         exp_last = g;
      end
      drive(0, 1'b0, 8'h00);
      drive(1, 1'b0, 8'h00);
      tick();

      // timeout: multiplier never answers
      dead = 1'b1;
      j = rjob();
      j2 = rjob();
      j3 = rjob();
      drive(0, 1'b1, j[0]);
      grant_chk(pick(2'b01, exp_last));
      send(0, j, -1, 0);
      w = 0;
      while (mm_start === 1'b1 && w < 30) begin
         tick();
         w++;
      end
      chk("issue_cycles", w, 18);
      drive(0, 1'b1, j2[0]);
      drive(1, 1'b1, j3[0]);
      w = 1;
      rv = 1'b0;
      while (err_timeout !== 1'b1 && w < 60) begin
         rv = rv | res_valid;
         tick();
         w++;
      end
      chk("to_delay", w, 21);
      chk("to_novalid", rv, 0);
      chk("to_busy", busy, 0);
      chk("to_ready", req_ready, 0);
      exp_last = 0;
      dead = 1'b0;
      tick();
      chk("to_once", err_timeout, 0);
      g = pick(2'b11, exp_last);
      chk("to_regrant", req_ready, (g == 1) ? 2'b10 : 2'b01);
      send(1, j3, -1, 0);
      collect(1, ref_mm(j3), 0);
      exp_last = 1;
      grant_chk(pick(2'b01, exp_last));
      send(0, j2, -1, 0);
      collect(0, ref_mm(j2), 2);
      exp_last = 0;

      // reset in the middle of the issue burst
      j = rjob();
      drive(1, 1'b1, j[0]);
      grant_chk(pick(2'b10, exp_last));
      send(1, j, -1, 0);
      repeat (10) tick();
      chk("mid_in", mm_in, j[10]);
      reset = 1'b1;
      #1;
      chk_reset("mid_rst");
      tick();
      reset = 1'b0;
      tick();
      chk_reset("post_rst");
      exp_last = 1;
      j = rjob();
      drive(0, 1'b1, j[0]);
      grant_chk(pick(2'b01, exp_last));
      b0 = bursts;
      send(0, j, -1, 0);
      collect(0, ref_mm(j), 0);
      issue_chk(j, b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
